// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundle of the signals that connect the arbiter to its two requesters
// (instruction fetch, load/store) and to the shared word memory.
//   master : environment side (core requesters + memory model)
//   slave  : arbiter side
// Requester signals : if_req_i, if_addr_i, if_gnt_o, if_rvalid_o, if_rdata_o,
//                     ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_gnt_o,
//                     ls_rvalid_o, ls_rdata_o
// Memory signals    : mem_re_o, mem_raddr_o, mem_rdata_i, mem_we_o,
//                     mem_waddr_o, mem_wdata_o
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int NUMWORDS  = 4096,
   parameter int DATAWIDTH = 32
);
   localparam int AW = $clog2(NUMWORDS);

   // fetch port (read-only)
   logic                 if_req_i;
   logic [AW-1:0]        if_addr_i;
   logic                 if_gnt_o;
   logic                 if_rvalid_o;
   logic [DATAWIDTH-1:0] if_rdata_o;

   // load/store port
   logic                 ls_req_i;
   logic                 ls_we_i;
   logic [AW-1:0]        ls_addr_i;
   logic [DATAWIDTH-1:0] ls_wdata_i;
   logic                 ls_gnt_o;
   logic                 ls_rvalid_o;
   logic [DATAWIDTH-1:0] ls_rdata_o;

   // memory side
   logic                 mem_re_o;
   logic [AW-1:0]        mem_raddr_o;
   logic [DATAWIDTH-1:0] mem_rdata_i;
   logic                 mem_we_o;
   logic [AW-1:0]        mem_waddr_o;
   logic [DATAWIDTH-1:0] mem_wdata_o;

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
      input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
      input  mem_re_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o,
      output mem_rdata_i
   );

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
      output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
      output mem_re_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o,
      input  mem_rdata_i
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester round-robin arbiter sharing a single-cycle word memory between
// the fetch unit (read-only) and the load/store unit (read/write). At most one
// transaction is granted per cycle; the grant is combinational and the response
// (read data or store ack) is registered and appears one cycle later.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave (requester handshakes + memory ports)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int NUMWORDS  = 4096,
   parameter int DATAWIDTH = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   mem_arbiter_if.slave  bus
);
   localparam int AW = $clog2(NUMWORDS);

   // Priority pointer: which port wins when both request.
   typedef enum logic {
      PRIO_IF = 1'b0,
      PRIO_LS = 1'b1
   } prio_e;

   prio_e                r_prio;
   prio_e                w_prio_next;

   logic                 w_if_gnt;
   logic                 w_ls_gnt;
   logic                 w_mem_re;
   logic [AW-1:0]        w_mem_raddr;
   logic                 w_mem_we;
   logic [AW-1:0]        w_mem_waddr;
   logic [DATAWIDTH-1:0] w_mem_wdata;

   logic                 r_if_rvalid;
   logic [DATAWIDTH-1:0] r_if_rdata;
   logic                 r_ls_rvalid;
   logic [DATAWIDTH-1:0] r_ls_rdata;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prio <= PRIO_IF;
      end else begin
         r_prio <= w_prio_next;
      end
   end

   // --------------------------------------- arbitration + memory steering
   always_comb begin
      w_prio_next = r_prio;
      w_if_gnt    = 1'b0;
      w_ls_gnt    = 1'b0;
      w_mem_re    = 1'b0;
      w_mem_raddr = '0;
      w_mem_we    = 1'b0;
      w_mem_waddr = '0;
      w_mem_wdata = '0;

      if (bus.if_req_i && bus.ls_req_i) begin
         if (r_prio == PRIO_IF) begin
            w_if_gnt = 1'b1;
         end else begin
            w_ls_gnt = 1'b1;
         end
      end else if (bus.if_req_i) begin
         w_if_gnt = 1'b1;
      end else if (bus.ls_req_i) begin
         w_ls_gnt = 1'b1;
      end

      // The pointer always flips to the port that did not just win.
      if (w_if_gnt) begin
         w_prio_next = PRIO_LS;
         w_mem_re    = 1'b1;
         w_mem_raddr = bus.if_addr_i;
      end else if (w_ls_gnt) begin
         w_prio_next = PRIO_IF;
         if (bus.ls_we_i) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = bus.ls_addr_i;
            w_mem_wdata = bus.ls_wdata_i;
         end else begin
            w_mem_re    = 1'b1;
            w_mem_raddr = bus.ls_addr_i;
         end
      end
   end

   // ---------------------------------------------------- response registers
   // The loser's rdata holds its last value; only rvalid is cleared.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_if_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_ls_rvalid <= 1'b0;
         r_ls_rdata  <= '0;
      end else begin
         r_if_rvalid <= w_if_gnt;
         r_ls_rvalid <= w_ls_gnt;
         if (w_if_gnt) begin
            r_if_rdata <= bus.mem_rdata_i;
         end
         if (w_ls_gnt) begin
            // store acks return zero data
            r_ls_rdata <= bus.ls_we_i ? '0 : bus.mem_rdata_i;
         end
      end
   end

   // -------------------------------------------------------------- outputs
   assign bus.if_gnt_o    = w_if_gnt;
   assign bus.ls_gnt_o    = w_ls_gnt;
   assign bus.if_rvalid_o = r_if_rvalid;
   assign bus.if_rdata_o  = r_if_rdata;
   assign bus.ls_rvalid_o = r_ls_rvalid;
   assign bus.ls_rdata_o  = r_ls_rdata;
   assign bus.mem_re_o    = w_mem_re;
   assign bus.mem_raddr_o = w_mem_raddr;
   assign bus.mem_we_o    = w_mem_we;
   assign bus.mem_waddr_o = w_mem_waddr;
   assign bus.mem_wdata_o = w_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter with a behavioural word memory
// (combinational read, write on rising edge). Inputs change 1 time unit after a
// rising edge; combinational outputs are sampled on the falling edge and
// registered outputs 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   localparam int NUMWORDS  = 4096;
   localparam int DATAWIDTH = 32;
   localparam int AW        = 12;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [DATAWIDTH-1:0] mem [0:NUMWORDS-1];

   mem_arbiter_if #(.NUMWORDS(NUMWORDS), .DATAWIDTH(DATAWIDTH)) bus ();

   mem_arbiter #(.NUMWORDS(NUMWORDS), .DATAWIDTH(DATAWIDTH)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model
   assign bus.mem_rdata_i = mem[bus.mem_raddr_o];
   always @(posedge clk) begin
      if (bus.mem_we_o) mem[bus.mem_waddr_o] <= bus.mem_wdata_o;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.if_req_i   = 1'b0;
      bus.if_addr_i  = '0;
      bus.ls_req_i   = 1'b0;
      bus.ls_we_i    = 1'b0;
      bus.ls_addr_i  = '0;
      bus.ls_wdata_i = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o, bus.mem_re_o, bus.mem_we_o} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_comb: gnt/re/we=%b expected 0000",
                  {bus.if_gnt_o, bus.ls_gnt_o, bus.mem_re_o, bus.mem_we_o});
      end
      checks++;
      if ({bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_rdata_o, bus.ls_rdata_o} !== '0) begin
         failures++;
         $display("FAIL reset_regs: rvalid=%b%b if_rdata=%h ls_rdata=%h expected zeros",
                  bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_rdata_o, bus.ls_rdata_o);
      end
      $display("reset: done");
      tick();
   endtask

   task automatic test_single_fetch();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 12'h010;
      @(negedge clk);
      checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o, bus.mem_re_o, bus.mem_we_o, bus.mem_raddr_o}
          !== {4'b1010, 12'h010}) begin
         failures++;
         $display("FAIL fetch_grant: gnt=%b%b re=%b we=%b raddr=%h expected 1 0 1 0 010",
                  bus.if_gnt_o, bus.ls_gnt_o, bus.mem_re_o, bus.mem_we_o, bus.mem_raddr_o);
      end
      tick();
      idle_inputs();
      checks++;
      if ({bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL fetch_resp: rvalid=%b%b rdata=%h expected 10 deadbeef",
                  bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_rdata_o);
      end
      $display("single_fetch: addr=010 rdata=%h", bus.if_rdata_o);
      tick();
      checks++;
      if (bus.if_rvalid_o !== 1'b0) begin
         failures++;
         $display("FAIL fetch_one_pulse: if_rvalid=%b expected 0", bus.if_rvalid_o);
      end
   endtask

   task automatic test_store_load();
      bus.ls_req_i   = 1'b1;
      bus.ls_we_i    = 1'b1;
      bus.ls_addr_i  = 12'h020;
      bus.ls_wdata_i = 32'h12345678;
      @(negedge clk);
      checks++;
      if ({bus.ls_gnt_o, bus.if_gnt_o, bus.mem_we_o, bus.mem_re_o, bus.mem_waddr_o, bus.mem_wdata_o}
          !== {4'b1010, 12'h020, 32'h12345678}) begin
         failures++;
         $display("FAIL store_drive: gnt=%b we=%b re=%b waddr=%h wdata=%h expected 1 1 0 020 12345678",
                  bus.ls_gnt_o, bus.mem_we_o, bus.mem_re_o, bus.mem_waddr_o, bus.mem_wdata_o);
      end
      tick();
      bus.ls_we_i    = 1'b0;
      bus.ls_wdata_i = '0;
      checks++;
      if ({bus.ls_rvalid_o, bus.if_rvalid_o, bus.ls_rdata_o} !== {2'b10, 32'h0}) begin
         failures++;
         $display("FAIL store_ack: rvalid=%b%b rdata=%h expected 10 00000000",
                  bus.ls_rvalid_o, bus.if_rvalid_o, bus.ls_rdata_o);
      end
      @(negedge clk);
      checks++;
      if ({bus.ls_gnt_o, bus.mem_re_o, bus.mem_we_o, bus.mem_raddr_o} !== {3'b110, 12'h020}) begin
         failures++;
         $display("FAIL load_drive: gnt=%b re=%b we=%b raddr=%h expected 1 1 0 020",
                  bus.ls_gnt_o, bus.mem_re_o, bus.mem_we_o, bus.mem_raddr_o);
      end
      tick();
      idle_inputs();
      checks++;
      if ({bus.ls_rvalid_o, bus.ls_rdata_o} !== {1'b1, 32'h12345678}) begin
         failures++;
         $display("FAIL load_after_store: rvalid=%b rdata=%h expected 1 12345678",
                  bus.ls_rvalid_o, bus.ls_rdata_o);
      end
      $display("store_load: addr=020 load rdata=%h", bus.ls_rdata_o);
   endtask

   task automatic test_contention();
      logic exp_f;
      do_reset();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 12'h010;
      bus.ls_req_i  = 1'b1;
      bus.ls_we_i   = 1'b0;
      bus.ls_addr_i = 12'h030;
      for (int i = 0; i < 6; i++) begin
         exp_f = (i % 2 == 0);
         @(negedge clk);
         checks++;
         if ({bus.if_gnt_o, bus.ls_gnt_o} !== {exp_f, ~exp_f}) begin
            failures++;
            $display("FAIL contend_gnt[%0d]: gnt=%b%b expected %b%b",
                     i, bus.if_gnt_o, bus.ls_gnt_o, exp_f, ~exp_f);
         end
         tick();
         checks++;
         if ({bus.if_rvalid_o, bus.ls_rvalid_o} !== {exp_f, ~exp_f} ||
             (exp_f  && bus.if_rdata_o !== 32'hDEADBEEF) ||
             (!exp_f && bus.ls_rdata_o !== 32'hA5000030)) begin
            failures++;
            $display("FAIL contend_resp[%0d]: rvalid=%b%b if_rdata=%h ls_rdata=%h expected rvalid %b%b",
                     i, bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_rdata_o, bus.ls_rdata_o,
                     exp_f, ~exp_f);
         end
         $display("contention: cycle %0d grant=%s", i, exp_f ? "F" : "L");
      end
      idle_inputs();
   endtask

   task automatic test_prio_after_load();
      // uncontended load leaves the pointer favouring fetch
      bus.ls_req_i  = 1'b1;
      bus.ls_addr_i = 12'h030;
      tick();
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 12'h010;
      @(negedge clk);
      checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b10) begin
         failures++;
         $display("FAIL prio_first: gnt=%b%b expected 10", bus.if_gnt_o, bus.ls_gnt_o);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b01) begin
         failures++;
         $display("FAIL prio_second: gnt=%b%b expected 01", bus.if_gnt_o, bus.ls_gnt_o);
      end
      tick();
      idle_inputs();
      $display("prio_after_load: F then L");
   endtask

   task automatic test_idle();
      // fetch at the top address leaves the pointer favouring load/store
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 12'hFFF;
      tick();
      idle_inputs();
      checks++;
      if ({bus.if_rvalid_o, bus.if_rdata_o} !== {1'b1, 32'hA5000FFF}) begin
         failures++;
         $display("FAIL fetch_top_addr: rvalid=%b rdata=%h expected 1 a5000fff",
                  bus.if_rvalid_o, bus.if_rdata_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.mem_re_o, bus.mem_we_o, bus.mem_raddr_o, bus.mem_waddr_o, bus.mem_wdata_o,
              bus.if_gnt_o, bus.ls_gnt_o} !== '0) begin
            failures++;
            $display("FAIL idle_mem[%0d]: re=%b we=%b raddr=%h waddr=%h wdata=%h expected all 0",
                     i, bus.mem_re_o, bus.mem_we_o, bus.mem_raddr_o, bus.mem_waddr_o,
                     bus.mem_wdata_o);
         end
         tick();
         checks++;
         if ({bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_rdata_o, bus.ls_rdata_o}
             !== {2'b00, 32'hA5000FFF, 32'hA5000030}) begin
            failures++;
            $display("FAIL idle_hold[%0d]: rvalid=%b%b if_rdata=%h ls_rdata=%h expected 00 a5000fff a5000030",
                     i, bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_rdata_o, bus.ls_rdata_o);
         end
         $display("idle: cycle %0d", i);
      end
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 12'h010;
      bus.ls_req_i  = 1'b1;
      bus.ls_addr_i = 12'h030;
      @(negedge clk);
      checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b01) begin
         failures++;
         $display("FAIL idle_prio_kept: gnt=%b%b expected 01", bus.if_gnt_o, bus.ls_gnt_o);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      // first fetch moves the pointer to load/store
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 12'h010;
      tick();
      @(negedge clk);
      checks++;
      if (bus.if_gnt_o !== 1'b1) begin
         failures++;
         $display("FAIL mid_gnt: if_gnt=%b expected 1", bus.if_gnt_o);
      end
      #1 rst_n = 1'b0;
      tick();
      checks++;
      if ({bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_rdata_o} !== '0) begin
         failures++;
         $display("FAIL mid_discard: rvalid=%b%b if_rdata=%h expected 00 00000000",
                  bus.if_rvalid_o, bus.ls_rvalid_o, bus.if_rdata_o);
      end
      rst_n = 1'b1;
      bus.ls_req_i  = 1'b1;
      bus.ls_addr_i = 12'h030;
      @(negedge clk);
      checks++;
      if ({bus.if_gnt_o, bus.ls_gnt_o} !== 2'b10) begin
         failures++;
         $display("FAIL mid_prio_reset: gnt=%b%b expected 10", bus.if_gnt_o, bus.ls_gnt_o);
      end
      tick();
      idle_inputs();
      $display("reset_mid: grant discarded, fetch first after release");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < NUMWORDS; i++) mem[i] = 32'hA5000000 | i;
      mem[12'h010] = 32'hDEADBEEF;
      test_reset();
      test_single_fetch();
      test_store_load();
      test_contention();
      test_prio_after_load();
      test_idle();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
